// File: rtl/scc_wave_ram_scheduler.sv
// scc_wave_ram_scheduler: time-slot scheduler for the shared single-port SCC wave RAM.
// Runs the per-round tone-read slot sequence for the channel mixer and slips CPU
// read/write accesses into it through a 4-phase req/ack handshake.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   cpu_req, cpu_we   CPU request level and direction (1 = write)
//   cpu_a, cpu_d      CPU address {channel[2:0], index[4:0]} and write data
//   cpu_ack, cpu_q    access complete (held until cpu_req drops), read data
//   slot, round_start current tone slot, pulse on the wrap from the last slot to 0
//   hold              mixer hold while the CPU owns the RAM
//   sram_oe, sram_we  RAM read/write strobes; sram_a/sram_d latched address/data
//   sram_q            RAM read data, one cycle after the address
// Optional feature: define SCC_SCHED_STARVE_GUARD_EN to limit the CPU to one access per round.
module scc_wave_ram_scheduler #(
    parameter int SLOT_COUNT  = 5,
    parameter int IDLE_SLOTS  = 1,
    parameter int PREFER_IDLE = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_a,
    input  logic [7:0] cpu_d,
    output logic       cpu_ack,
    output logic [7:0] cpu_q,
    output logic [2:0] slot,
    output logic       round_start,
    output logic       hold,
    output logic       sram_oe,
    output logic       sram_we,
    output logic [7:0] sram_a,
    output logic [7:0] sram_d,
    input  logic [7:0] sram_q
);
    localparam logic [2:0] LAST = 3'(SLOT_COUNT + IDLE_SLOTS - 1);

    typedef enum logic [1:0] {RUN, ACCESS, CAPTURE, ACK} state_t;

    state_t     state, state_next;
    logic       we_l;
    logic [7:0] a_l, d_l;
    logic       run_slot, wrap, eligible, accept;

    // The slot counter only stalls for the single cycle the CPU owns the RAM.
    assign run_slot = state != ACCESS;
    assign wrap     = run_slot && slot == LAST;
    // Compare in 4 bits so a SLOT_COUNT of 8 does not alias to slot 0.
    assign eligible = PREFER_IDLE == 0 || {1'b0, slot} >= 4'(SLOT_COUNT);

`ifdef SCC_SCHED_STARVE_GUARD_EN
    logic used;
    assign accept = state == RUN && cpu_req && eligible && !used;
    // An accept on the wrap cycle lands its ACCESS in the new round, so it must
    // count against that round: setting wins over clearing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            used <= 1'b0;
        else if (accept)
            used <= 1'b1;
        else if (wrap)
            used <= 1'b0;
    end
`else
    assign accept = state == RUN && cpu_req && eligible;
`endif

    always_comb begin
        state_next = state;
        case (state)
            RUN:     state_next = accept ? ACCESS : RUN;
            ACCESS:  state_next = CAPTURE;
            CAPTURE: state_next = ACK;
            ACK:     state_next = cpu_req ? ACK : RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            slot  <= '0;
            we_l  <= 1'b0;
            a_l   <= '0;
            d_l   <= '0;
            cpu_q <= '0;
        end else begin
            state <= state_next;
            if (run_slot)
                slot <= wrap ? '0 : slot + 3'd1;
            if (accept) begin
                we_l <= cpu_we;
                a_l  <= cpu_a;
                d_l  <= cpu_d;
            end
            // RAM data for the ACCESS-cycle address is valid during CAPTURE.
            if (state == CAPTURE && !we_l)
                cpu_q <= sram_q;
        end
    end

    assign round_start = wrap;
    assign cpu_ack     = state == ACK;
    assign hold        = state == ACCESS;
    assign sram_oe     = state == ACCESS && !we_l;
    assign sram_we     = state == ACCESS && we_l;
    assign sram_a      = a_l;
    assign sram_d      = d_l;
endmodule

// File: tb/tb_scc_wave_ram_scheduler.sv
// tb_scc_wave_ram_scheduler: directed bench for the SCC wave RAM scheduler.
// u0 uses PREFER_IDLE=0, u1 uses PREFER_IDLE=1; each has its own RAM model
// preloaded with mem[i] = i ^ 8'hA5 (so RAM[8'h23] = 8'h86).
module tb_scc_wave_ram_scheduler;
`ifdef SCC_SCHED_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1;
    logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [7:0] a0 = 0, d0 = 0, a1 = 0, d1 = 0;
    logic ack0, rs0, hold0, oe0, swe0, ack1, rs1, hold1, oe1, swe1;
    logic [7:0] q0, sa0, sd0, q1, sa1, sd1;
    logic [7:0] sq0 = 0, sq1 = 0;
    logic [2:0] slot0, slot1;
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    bit ram_ready = 1'b0;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    scc_wave_ram_scheduler #(.PREFER_IDLE(0)) u0 (
        .clk(clk), .reset(reset), .cpu_req(req0), .cpu_we(we0), .cpu_a(a0), .cpu_d(d0),
        .cpu_ack(ack0), .cpu_q(q0), .slot(slot0), .round_start(rs0), .hold(hold0),
        .sram_oe(oe0), .sram_we(swe0), .sram_a(sa0), .sram_d(sd0), .sram_q(sq0));

    scc_wave_ram_scheduler #(.PREFER_IDLE(1)) u1 (
        .clk(clk), .reset(reset), .cpu_req(req1), .cpu_we(we1), .cpu_a(a1), .cpu_d(d1),
        .cpu_ack(ack1), .cpu_q(q1), .slot(slot1), .round_start(rs1), .hold(hold1),
        .sram_oe(oe1), .sram_we(swe1), .sram_a(sa1), .sram_d(sd1), .sram_q(sq1));

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= 8'(i) ^ 8'hA5;
                mem1[i] <= 8'(i) ^ 8'hA5;
            end
            ram_ready <= 1'b1;
        end else begin
            if (swe0) mem0[sa0] <= sd0;
            if (swe1) mem1[sa1] <= sd1;
            sq0 <= mem0[sa0];
            sq1 <= mem1[sa1];
        end
    end

    task step;
        @(posedge clk);
        #1;
    endtask

    task test_reset;
        reset = 1'b1;
        step;
        step;
        checks++; if ({slot0, rs0, ack0, hold0, oe0, swe0, sa0, sd0, q0} !== 32'h0) begin errors++; $display("FAIL reset_outputs_u0 got %h want 0", {slot0, rs0, ack0, hold0, oe0, swe0, sa0, sd0, q0}); end
        checks++; if ({slot1, rs1, ack1, hold1, oe1, swe1, sa1, sd1, q1} !== 32'h0) begin errors++; $display("FAIL reset_outputs_u1 got %h want 0", {slot1, rs1, ack1, hold1, oe1, swe1, sa1, sd1, q1}); end
        reset = 1'b0;
        for (int k = 0; k < 14; k++) begin
            checks++; if (slot0 !== 3'(k % 6)) begin errors++; $display("FAIL idle_slot_u0 k=%0d got %0d want %0d", k, slot0, k % 6); end
            checks++; if (slot1 !== 3'(k % 6)) begin errors++; $display("FAIL idle_slot_u1 k=%0d got %0d want %0d", k, slot1, k % 6); end
            checks++; if (rs0 !== (k % 6 == 5)) begin errors++; $display("FAIL idle_round_start k=%0d got %b want %b", k, rs0, k % 6 == 5); end
            checks++; if ({oe0, swe0, hold0, ack0, oe1, swe1, hold1, ack1} !== 8'h0) begin errors++; $display("FAIL idle_strobes k=%0d got %b want 0", k, {oe0, swe0, hold0, ack0, oe1, swe1, hold1, ack1}); end
            step;
        end
    endtask

    task test_read;
        for (int n = 0; n < 8 && slot0 != 3'd2; n++) step;
        req0 = 1'b1; we0 = 1'b0; a0 = 8'h23;
        step;
        checks++; if ({oe0, swe0, hold0, ack0} !== 4'b1010) begin errors++; $display("FAIL read_access_strobes got %b want 1010", {oe0, swe0, hold0, ack0}); end
        checks++; if (sa0 !== 8'h23) begin errors++; $display("FAIL read_sram_a got %h want 23", sa0); end
        checks++; if (slot0 !== 3'd3) begin errors++; $display("FAIL read_slot_access got %0d want 3", slot0); end
        step;
        checks++; if (slot0 !== 3'd3) begin errors++; $display("FAIL read_slot_frozen got %0d want 3", slot0); end
        checks++; if ({oe0, hold0, ack0} !== 3'b000) begin errors++; $display("FAIL read_capture_strobes got %b want 000", {oe0, hold0, ack0}); end
        step;
        checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL read_ack_latency got %b want 1", ack0); end
        checks++; if (q0 !== 8'h86) begin errors++; $display("FAIL read_data got %h want 86", q0); end
        checks++; if (slot0 !== 3'd4) begin errors++; $display("FAIL read_slot_ack got %0d want 4", slot0); end
        req0 = 1'b0;
        step;
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL read_ack_drop got %b want 0", ack0); end
    endtask

    task test_write;
        int pulses, n;
        logic [7:0] seen_d;
        pulses = 0; seen_d = 8'h00;
        req0 = 1'b1; we0 = 1'b1; a0 = 8'h41; d0 = 8'h5A;
        for (int i = 0; i < 6; i++) begin
            step;
            if (swe0) begin pulses++; seen_d = sd0; end
            checks++; if (oe0 !== 1'b0) begin errors++; $display("FAIL write_no_oe i=%0d got %b want 0", i, oe0); end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL write_pulse_count got %0d want 1", pulses); end
        checks++; if (seen_d !== 8'h5A) begin errors++; $display("FAIL write_sram_d got %h want 5a", seen_d); end
        checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL write_ack got %b want 1", ack0); end
        checks++; if (q0 !== 8'h86) begin errors++; $display("FAIL write_q_unchanged got %h want 86", q0); end
        req0 = 1'b0;
        step;
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL write_ack_drop got %b want 0", ack0); end
        req0 = 1'b1; we0 = 1'b0; a0 = 8'h41;
        n = 0;
        do begin step; n++; end while (!ack0 && n < 12);
        checks++; if (GUARD ? (n > 9) : (n != 3)) begin errors++; $display("FAIL readback_latency got %0d want %s", n, GUARD ? "<=9" : "3"); end
        checks++; if (q0 !== 8'h5A) begin errors++; $display("FAIL readback_data got %h want 5a", q0); end
        req0 = 1'b0;
        step;
    endtask

    task test_prefer_idle;
        int rs, strobes;
        rs = 0; strobes = 0;
        for (int n = 0; n < 8 && slot1 != 3'd1; n++) step;
        req1 = 1'b1; we1 = 1'b0; a1 = 8'h23;
        for (int i = 0; i < 4; i++) begin
            step;
            rs += int'(rs1);
            strobes += int'(oe1 | swe1 | hold1);
        end
        checks++; if (strobes !== 0) begin errors++; $display("FAIL idle_pref_early_strobe got %0d want 0", strobes); end
        checks++; if (slot1 !== 3'd5) begin errors++; $display("FAIL idle_pref_slot_before got %0d want 5", slot1); end
        step;
        rs += int'(rs1);
        checks++; if ({oe1, hold1} !== 2'b11) begin errors++; $display("FAIL idle_pref_access got %b want 11", {oe1, hold1}); end
        checks++; if (slot1 !== 3'd0) begin errors++; $display("FAIL idle_pref_slot_held got %0d want 0", slot1); end
        step;
        rs += int'(rs1);
        checks++; if (slot1 !== 3'd0) begin errors++; $display("FAIL idle_pref_slot_frozen got %0d want 0", slot1); end
        step;
        checks++; if (ack1 !== 1'b1 || q1 !== 8'h86) begin errors++; $display("FAIL idle_pref_ack got ack=%b q=%h want ack=1 q=86", ack1, q1); end
        checks++; if (rs !== 1) begin errors++; $display("FAIL idle_pref_round_start got %0d want 1", rs); end
        req1 = 1'b0;
        step;
    endtask

    task test_hold_req;
        int n, extra, lows;
        extra = 0; lows = 0;
        req0 = 1'b1; we0 = 1'b0; a0 = 8'h41;
        n = 0;
        do begin step; n++; end while (!oe0 && n < 10);
        checks++; if (GUARD ? (n > 7) : (n != 1)) begin errors++; $display("FAIL hold_first_grant got %0d want %s", n, GUARD ? "<=7" : "1"); end
        for (int i = 1; i <= 12; i++) begin
            step;
            extra += int'(oe0 | swe0);
            if (i >= 2 && !ack0) lows++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL hold_extra_access got %0d want 0", extra); end
        checks++; if (lows !== 0) begin errors++; $display("FAIL hold_ack_dropped got %0d want 0", lows); end
        checks++; if (q0 !== 8'h5A) begin errors++; $display("FAIL hold_data got %h want 5a", q0); end
        req0 = 1'b0;
        step;
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL hold_ack_drop got %b want 0", ack0); end
        req0 = 1'b1; a0 = 8'h23;
        n = 0;
        do begin step; n++; end while (!oe0 && n < 10);
        checks++; if (GUARD ? (n > 7) : (n != 1)) begin errors++; $display("FAIL hold_regrant got %0d want %s", n, GUARD ? "<=7" : "1"); end
        n = 0;
        do begin step; n++; end while (!ack0 && n < 10);
        checks++; if (n !== 2 || q0 !== 8'h86) begin errors++; $display("FAIL hold_regrant_data got n=%0d q=%h want n=2 q=86", n, q0); end
        req0 = 1'b0;
        step;
    endtask

    task test_reset_mid;
        int n;
        req0 = 1'b1; we0 = 1'b0; a0 = 8'h23;
        n = 0;
        while (!oe0 && n < 10) begin step; n++; end
        checks++; if (oe0 !== 1'b1) begin errors++; $display("FAIL midreset_no_access got %b want 1", oe0); end
        reset = 1'b1;
        #1;
        checks++; if ({oe0, hold0, ack0, swe0} !== 4'b0000) begin errors++; $display("FAIL midreset_strobes got %b want 0000", {oe0, hold0, ack0, swe0}); end
        checks++; if (slot0 !== 3'd0 || q0 !== 8'h00) begin errors++; $display("FAIL midreset_state got slot=%0d q=%h want 0 00", slot0, q0); end
        req0 = 1'b0;
        step;
        reset = 1'b0;
        step;
        checks++; if (slot0 !== 3'd1 || ack0 !== 1'b0) begin errors++; $display("FAIL midreset_resume got slot=%0d ack=%b want 1 0", slot0, ack0); end
        step;
        checks++; if (slot0 !== 3'd2) begin errors++; $display("FAIL midreset_resume2 got %0d want 2", slot0); end
    endtask

    task test_back_to_back;
        int n, rs;
        reset = 1'b1;
        step;
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b1; a0 = 8'h10; d0 = 8'h33;
        n = 0;
        do begin step; n++; end while (!ack0 && n < 10);
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_first_latency got %0d want 3", n); end
        req0 = 1'b0;
        step;
        checks++; if (slot0 !== 3'd3) begin errors++; $display("FAIL b2b_slot got %0d want 3", slot0); end
        req0 = 1'b1; we0 = 1'b0;
        n = 0; rs = 0;
        do begin step; n++; rs += int'(rs0); end while (!oe0 && n < 10);
        checks++; if (n !== (GUARD ? 4 : 1)) begin errors++; $display("FAIL b2b_second_grant got %0d want %0d", n, GUARD ? 4 : 1); end
        checks++; if (slot0 !== (GUARD ? 3'd1 : 3'd4)) begin errors++; $display("FAIL b2b_second_slot got %0d want %0d", slot0, GUARD ? 1 : 4); end
        checks++; if (rs !== (GUARD ? 1 : 0)) begin errors++; $display("FAIL b2b_round_start got %0d want %0d", rs, GUARD ? 1 : 0); end
        n = 0;
        do begin step; n++; end while (!ack0 && n < 10);
        checks++; if (q0 !== 8'h33) begin errors++; $display("FAIL b2b_data got %h want 33", q0); end
        req0 = 1'b0;
        step;
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL b2b_ack_drop got %b want 0", ack0); end
    endtask

    initial begin
        test_reset;
        test_read;
        test_write;
        test_prefer_idle;
        test_hold_req;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
